// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit with zero/ones/parity flags.
// Define LOGIC_UNIT_STATS_EN to build the completed-result counter on out_count.
module logic_unit_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_y,
    output logic               out_zero,
    output logic               out_ones,
    output logic               out_par,
    output logic [COUNT_W-1:0] out_count
);

    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [2:0]       s1_op_r;
    logic             s1_v_r;
    logic             s2_load_s;
    logic             in_accept_s;
    logic             out_take_s;
    logic [WIDTH-1:0] y_s;

    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    assign s2_load_s   = s1_v_r && (!out_valid || out_ready);
    assign in_ready    = !s1_v_r || s2_load_s;
    assign in_accept_s = in_valid && in_ready;
    assign out_take_s  = out_valid && out_ready;

    // Stage-1 operand capture and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a_r  <= '0;
            s1_b_r  <= '0;
            s1_op_r <= 3'd0;
            s1_v_r  <= 1'b0;
        end else if (in_accept_s) begin
            s1_a_r  <= in_a;
            s1_b_r  <= in_b;
            s1_op_r <= in_op;
            s1_v_r  <= 1'b1;
        end else if (s2_load_s) begin
            s1_v_r  <= 1'b0;
        end else begin
            s1_v_r  <= s1_v_r;
        end
    end

    // Operation decode on the stage-1 operands
    always_comb begin
        y_s = '0;
        case (s1_op_r)
            3'd0:    y_s = s1_a_r & s1_b_r;
            3'd1:    y_s = s1_a_r | s1_b_r;
            3'd2:    y_s = s1_a_r ^ s1_b_r;
            3'd3:    y_s = ~(s1_a_r & s1_b_r);
            3'd4:    y_s = ~(s1_a_r | s1_b_r);
            3'd5:    y_s = ~(s1_a_r ^ s1_b_r);
            3'd6:    y_s = ~s1_a_r;
            default: y_s = s1_b_r;
        endcase
    end

    // Stage-2 result and flags; flags are loaded together with out_y so they always match it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_zero  <= 1'b1;
            out_ones  <= 1'b0;
            out_par   <= 1'b0;
        end else if (s2_load_s) begin
            out_valid <= 1'b1;
            out_y     <= y_s;
            out_zero  <= (y_s == '0);
            out_ones  <= (y_s == '1);
            out_par   <= parity_f(y_s);
        end else if (out_take_s) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

`ifdef LOGIC_UNIT_STATS_EN
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);
    logic [COUNT_W-1:0] count_r;

    // Completed-result counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (out_take_s) begin
            count_r <= count_r + COUNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign out_count = count_r;
`else
    assign out_count = '0;
`endif

endmodule
